// File: rtl/vram_stream_if.sv
// Bundles the CPU word port and the video burst-stream port of vram_stream.
// Latency: none (wires only).
// Backpressure: pix_valid/pix_ready on the pixel stream; the CPU side never stalls.
interface vram_stream_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14,
    parameter int PIX_W  = 8
);
    localparam int NB  = DATA_W / 8;
    localparam int PPW = DATA_W / PIX_W;
    localparam int PB  = $clog2(PPW);

    // CPU word port
    logic              cpu_we;
    logic              cpu_re;
    logic [ADDR_W-1:0] cpu_addr;
    logic [NB-1:0]     cpu_be;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_rvalid;

    // Video burst control
    logic                 vid_start;
    logic [ADDR_W+PB-1:0] vid_addr;
    logic [15:0]          vid_len;
    logic                 vid_abort;
    logic                 vid_busy;
    logic                 vid_done;

    // Pixel stream
    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;

    // Bus glue / scan-out side
    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_be, cpu_din,
        input  cpu_dout, cpu_rvalid,
        output vid_start, vid_addr, vid_len, vid_abort,
        input  vid_busy, vid_done,
        input  pix_data, pix_valid,
        output pix_ready
    );

    // The video RAM itself
    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_be, cpu_din,
        output cpu_dout, cpu_rvalid,
        input  vid_start, vid_addr, vid_len, vid_abort,
        output vid_busy, vid_done,
        output pix_data, pix_valid,
        input  pix_ready
    );
endinterface

// File: rtl/vram_stream.sv
// Video RAM with a byte-laned CPU word port and a burst pixel streamer.
// Latency: CPU read 1 cycle; first pixel 3 cycles after an accepted vid_start.
// Backpressure: pix_ready stalls the serializer; prefetch stops when the word FIFO is full.
module vram_stream #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 14,
    parameter int PIX_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic        clk,
    input logic        reset,
    vram_stream_if.slave bus
);
    localparam int NB  = DATA_W / 8;
    localparam int PPW = DATA_W / PIX_W;
    localparam int PB  = $clog2(PPW);
    localparam int PBW = (PB > 0) ? PB : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = FAW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [1:0]        state;
    logic [ADDR_W-1:0] word_ptr;
    logic [16:0]       words_left;
    logic [15:0]       remaining;
    logic [PBW-1:0]    lane;

    // One-deep read pipeline between the RAM and the FIFO
    logic              rd_vld;
    logic [DATA_W-1:0] rd_dat;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]    wr_ptr;
    logic [FAW-1:0]    rd_ptr;
    logic [CW-1:0]     count;

    logic              done_q;
    logic [DATA_W-1:0] dout_q;
    logic              rvalid_q;

    logic              issue;
    logic              push;
    logic              pop;
    logic              fire;
    logic              pix_vld;
    logic              last_lane;
    logic              last_pix;
    logic [DATA_W-1:0] head;
    logic [PIX_W-1:0]  chunk;
    logic [ADDR_W-1:0] start_word;
    logic [PBW-1:0]    start_off;
    logic [16:0]       start_words;

    // Issue a fetch only while the FIFO plus the word in flight still has room
    assign issue = (state == ST_FETCH) && !bus.vid_abort && (words_left != 17'd0) &&
                   ((32'(count) + 32'(rd_vld)) < FIFO_DEPTH);
    assign push  = rd_vld;

    assign head      = fifo_mem[rd_ptr];
    assign chunk     = head[(DATA_W - 1 - 32'(lane) * PIX_W) -: PIX_W];
    assign pix_vld   = (count != '0) && (remaining != 16'd0);
    assign fire      = pix_vld && bus.pix_ready && !bus.vid_abort;
    assign last_lane = (lane == PBW'(PPW - 1));
    assign last_pix  = (remaining == 16'd1);
    assign pop       = fire && (last_lane || last_pix);

    // Split the pixel address into word and lane; count words covering offset+len
    assign start_word  = ADDR_W'(bus.vid_addr >> PB);
    assign start_off   = PBW'(32'(bus.vid_addr) % PPW);
    assign start_words = 17'((32'(start_off) + 32'(bus.vid_len) + PPW - 1) / PPW);

    assign bus.cpu_dout   = dout_q;
    assign bus.cpu_rvalid = rvalid_q;
    assign bus.vid_busy   = (state != ST_IDLE);
    assign bus.vid_done   = done_q;
    assign bus.pix_valid  = pix_vld;
    assign bus.pix_data   = pix_vld ? chunk : '0;

    // RAM array: byte-laned CPU writes and the streamer's registered fetch (read-first)
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (bus.cpu_we && bus.cpu_be[i]) begin
                mem[bus.cpu_addr][8*i +: 8] <= bus.cpu_din[8*i +: 8];
            end
        end
        if (issue) begin
            rd_dat <= mem[word_ptr];
        end
    end

    // FIFO storage: fetched word lands one cycle after issue
    always_ff @(posedge clk) begin
        if (push && !bus.vid_abort) begin
            fifo_mem[wr_ptr] <= rd_dat;
        end
    end

    // CPU read port: one-cycle latency, output held between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= bus.cpu_re;
            if (bus.cpu_re) begin
                dout_q <= mem[bus.cpu_addr];
            end
        end
    end

    // Burst control FSM, FIFO pointers and pixel serializer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            word_ptr   <= '0;
            words_left <= '0;
            remaining  <= '0;
            lane       <= '0;
            rd_vld     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.vid_abort) begin
                // Flush everything; the word in flight is dropped and no done pulse is given
                state      <= ST_IDLE;
                words_left <= '0;
                remaining  <= '0;
                lane       <= '0;
                rd_vld     <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
            end else begin
                rd_vld <= issue;
                if (issue) begin
                    word_ptr   <= word_ptr + 1'b1;
                    words_left <= words_left - 17'd1;
                    if (words_left == 17'd1) begin
                        state <= ST_DRAIN;
                    end
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
                if (fire) begin
                    remaining <= remaining - 16'd1;
                    lane      <= (last_lane || last_pix) ? '0 : lane + 1'b1;
                    if (last_pix) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                if (state == ST_IDLE && bus.vid_start) begin
                    if (bus.vid_len == 16'd0) begin
                        done_q <= 1'b1;
                    end else begin
                        state      <= ST_FETCH;
                        word_ptr   <= start_word;
                        lane       <= start_off;
                        remaining  <= bus.vid_len;
                        words_left <= start_words;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vram_stream.sv
// Directed self-checking bench for vram_stream (DATA_W=16, ADDR_W=14, PIX_W=8).
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Every stream wait runs for a fixed cycle budget, so the run always terminates.
module tb_vram_stream;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vram_stream_if #(.DATA_W(16), .ADDR_W(14), .PIX_W(8)) bus ();

    vram_stream #(.DATA_W(16), .ADDR_W(14), .PIX_W(8), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] got_pix [32];
    logic [7:0] exp_pix [32];
    int         npix;
    int         ndone;
    logic       first_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [13:0] addr, input logic [1:0] be, input logic [15:0] din);
        bus.cpu_we   = 1'b1;
        bus.cpu_addr = addr;
        bus.cpu_be   = be;
        bus.cpu_din  = din;
        @(posedge clk); #1;
        bus.cpu_we   = 1'b0;
    endtask

    task automatic cpu_read(input logic [13:0] addr, output logic [15:0] d, output logic rv);
        bus.cpu_re   = 1'b1;
        bus.cpu_addr = addr;
        @(posedge clk); #1;
        bus.cpu_re   = 1'b0;
        d  = bus.cpu_dout;
        rv = bus.cpu_rvalid;
    endtask

    // Start a burst and watch the stream for a fixed number of cycles
    task automatic run_stream(input logic [14:0] addr, input logic [15:0] len,
                              input bit toggle, input int cycles);
        logic       prev_v;
        logic       prev_r;
        logic [7:0] prev_d;
        npix       = 0;
        ndone      = 0;
        first_busy = 1'b0;
        prev_v     = 1'b0;
        prev_r     = 1'b1;
        prev_d     = '0;
        bus.vid_addr  = addr;
        bus.vid_len   = len;
        bus.vid_start = 1'b1;
        @(posedge clk); #1;
        bus.vid_start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            bus.pix_ready = toggle ? i[0] : 1'b1;
            @(negedge clk);
            if (i == 0) first_busy = bus.vid_busy;
            if (prev_v && !prev_r) begin
                check("hold_valid", 32'(bus.pix_valid), 32'd1);
                check("hold_data", 32'(bus.pix_data), 32'(prev_d));
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (npix < 32) got_pix[npix] = bus.pix_data;
                npix++;
            end
            if (bus.vid_done) ndone++;
            prev_v = bus.pix_valid;
            prev_r = bus.pix_ready;
            prev_d = bus.pix_data;
            @(posedge clk); #1;
        end
        bus.pix_ready = 1'b1;
    endtask

    task automatic check_stream(input string tag, input int n);
        check({tag, "_npix"}, 32'(npix), 32'(n));
        check({tag, "_done"}, 32'(ndone), 32'd1);
        check({tag, "_busy_end"}, 32'(bus.vid_busy), 32'd0);
        for (int k = 0; k < n && k < npix; k++) begin
            check($sformatf("%s_pix%0d", tag, k), 32'(got_pix[k]), 32'(exp_pix[k]));
        end
    endtask

    initial begin
        logic [15:0] d;
        logic        rv;
        int          fired;
        int          nvalid;

        reset         = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_be    = '0;
        bus.cpu_din   = '0;
        bus.vid_start = 1'b0;
        bus.vid_addr  = '0;
        bus.vid_len   = '0;
        bus.vid_abort = 1'b0;
        bus.pix_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", 32'(bus.cpu_dout), 32'd0);
        check("rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("rst_busy", 32'(bus.vid_busy), 32'd0);
        check("rst_done", 32'(bus.vid_done), 32'd0);
        check("rst_pvalid", 32'(bus.pix_valid), 32'd0);
        check("rst_pdata", 32'(bus.pix_data), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Byte-lane writes then read back
        cpu_write(14'd5, 2'b11, 16'hABCD);
        cpu_write(14'd5, 2'b01, 16'h1234);
        check("rvalid_before", 32'(bus.cpu_rvalid), 32'd0);
        cpu_read(14'd5, d, rv);
        check("lane_read", 32'(d), 32'hAB34);
        check("rvalid_pulse", 32'(rv), 32'd1);
        @(posedge clk); #1;
        check("rvalid_drop", 32'(bus.cpu_rvalid), 32'd0);
        check("dout_hold", 32'(bus.cpu_dout), 32'hAB34);

        // Same-cycle read and write: old data comes back
        cpu_write(14'd7, 2'b11, 16'h1111);
        bus.cpu_we   = 1'b1;
        bus.cpu_re   = 1'b1;
        bus.cpu_addr = 14'd7;
        bus.cpu_be   = 2'b11;
        bus.cpu_din  = 16'h2222;
        @(posedge clk); #1;
        bus.cpu_we   = 1'b0;
        bus.cpu_re   = 1'b0;
        check("rw_old", 32'(bus.cpu_dout), 32'h1111);
        cpu_read(14'd7, d, rv);
        check("rw_new", 32'(d), 32'h2222);

        // Stream from pixel 1, four pixels, always ready
        cpu_write(14'd0, 2'b11, 16'h0102);
        cpu_write(14'd1, 2'b11, 16'h0304);
        cpu_write(14'd2, 2'b11, 16'h0506);
        exp_pix[0] = 8'h02; exp_pix[1] = 8'h03; exp_pix[2] = 8'h04; exp_pix[3] = 8'h05;
        run_stream(15'd1, 16'd4, 1'b0, 40);
        check("s1_busy_start", 32'(first_busy), 32'd1);
        check_stream("s1", 4);

        // Same stream with pix_ready toggling
        run_stream(15'd1, 16'd4, 1'b1, 40);
        check_stream("s2", 4);

        // Wrap from the last word to word 0
        cpu_write(14'h3FFF, 2'b11, 16'hA1A2);
        exp_pix[0] = 8'hA1; exp_pix[1] = 8'hA2; exp_pix[2] = 8'h01; exp_pix[3] = 8'h02;
        run_stream(15'h7FFE, 16'd4, 1'b0, 40);
        check_stream("wrap", 4);

        // Abort after two of ten pixels
        cpu_write(14'd8,  2'b11, 16'h1011);
        cpu_write(14'd9,  2'b11, 16'h1213);
        cpu_write(14'd10, 2'b11, 16'h1415);
        cpu_write(14'd11, 2'b11, 16'h1617);
        cpu_write(14'd12, 2'b11, 16'h1819);
        bus.vid_addr  = 15'd16;
        bus.vid_len   = 16'd10;
        bus.vid_start = 1'b1;
        bus.pix_ready = 1'b1;
        @(posedge clk); #1;
        bus.vid_start = 1'b0;
        fired = 0;
        ndone = 0;
        for (int i = 0; i < 40 && fired < 2; i++) begin
            @(negedge clk);
            if (bus.pix_valid && bus.pix_ready) begin
                got_pix[fired] = bus.pix_data;
                fired++;
            end
            if (bus.vid_done) ndone++;
            @(posedge clk); #1;
        end
        check("abort_fired", 32'(fired), 32'd2);
        check("abort_pix0", 32'(got_pix[0]), 32'h10);
        check("abort_pix1", 32'(got_pix[1]), 32'h11);
        bus.vid_abort = 1'b1;
        bus.pix_ready = 1'b0;
        @(posedge clk); #1;
        bus.vid_abort = 1'b0;
        check("abort_pvalid", 32'(bus.pix_valid), 32'd0);
        check("abort_busy", 32'(bus.vid_busy), 32'd0);
        bus.pix_ready = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.pix_valid) nvalid++;
            if (bus.vid_done) ndone++;
            @(posedge clk); #1;
        end
        check("abort_no_valid", 32'(nvalid), 32'd0);
        check("abort_no_done", 32'(ndone), 32'd0);

        // Fresh burst after the abort
        exp_pix[0] = 8'h10; exp_pix[1] = 8'h11; exp_pix[2] = 8'h12;
        run_stream(15'd16, 16'd3, 1'b0, 30);
        check_stream("post_abort", 3);

        // Zero-length start: done pulse, never busy, no pixels
        run_stream(15'd16, 16'd0, 1'b0, 10);
        check("len0_npix", 32'(npix), 32'd0);
        check("len0_done", 32'(ndone), 32'd1);
        check("len0_busy", 32'(first_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vram_stream.md
Name: vram_stream

Overview:
- Parametrised single-clock video RAM.
- CPU port: word-wide access with per-byte lane enables.
- Video port: replaces single-byte random reads with a burst pixel streamer. Given a start pixel address and a length, it fetches words, serialises them into PIX_W-bit pixels and delivers them over a valid/ready stream through a small word FIFO.
- Sits between the 68k bus glue and the display/scan-out logic.

Parameters:
- DATA_W, 16: word width; multiple of 8. NB = DATA_W/8 byte lanes.
- ADDR_W, 14: word address width; depth is 2^ADDR_W words.
- PIX_W, 8: pixel width; must divide DATA_W. PPW = DATA_W/PIX_W pixels per word; PB = log2(PPW).
- FIFO_DEPTH, 4: prefetch word FIFO depth; power of 2, ≥2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_we  in  1  write strobe.
- cpu_re  in  1  read strobe.
- cpu_addr  in  ADDR_W  word address.
- cpu_be  in  NB  lane enables; bit i covers data[8i+7:8i].
- cpu_din  in  DATA_W  write data.
- cpu_dout  out  DATA_W  read data.
- cpu_rvalid  out  1  one-cycle pulse when cpu_dout is updated.
- vid_start  in  1  start burst; accepted only when vid_busy=0.
- vid_addr  in  ADDR_W+PB  start pixel address; upper ADDR_W bits = word, low PB bits = pixel within word.
- vid_len  in  16  pixel count.
- vid_abort  in  1  cancel the current burst.
- vid_busy  out  1  burst in progress.
- vid_done  out  1  one-cycle pulse after the last pixel handshake.
- pix_data  out  PIX_W  pixel.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer accepts pixel.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; FIFO empty; counters 0. Memory contents are not reset.
- CPU write: in the cycle cpu_we=1, each lane i with cpu_be[i]=1 is written. Lanes with cpu_be[i]=0 are untouched.
- CPU read: cpu_re=1 gives cpu_dout = word at cpu_addr on the next edge (1-cycle latency) and pulses cpu_rvalid. cpu_dout holds its value otherwise.
- CPU read and write to the same address in the same cycle: read-first, so cpu_dout returns the old word.
- Pixel order: pixel index 0 in a word is the most significant chunk, data[DATA_W-1:DATA_W-PIX_W]. At DATA_W=16/PIX_W=8, even pixel address = upper byte.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - vid_start with vid_len≠0: latch word pointer, pixel offset and remaining count; go to FETCH; vid_busy=1 from the next cycle.
  - vid_start with vid_len=0: stay in IDLE; pulse vid_done next cycle; vid_busy stays 0.
  - vid_start while busy is ignored.
- FETCH:
  - Issue one internal read per cycle while (FIFO occupancy + in-flight reads) < FIFO_DEPTH.
  - Read data is pushed into the FIFO 1 cycle after issue.
  - Word pointer increments and wraps from 2^ADDR_W-1 to 0.
  - Stop issuing once words issued = ceil((offset+len)/PPW); go to DRAIN.
- DRAIN: wait until all pixels are accepted.
- Serializer:
  - Presents FIFO head chunk at the current lane index; pix_valid=1 whenever the FIFO is non-empty and remaining>0.
  - On pix_valid&pix_ready: remaining decrements and lane index increments. At lane PPW-1 the FIFO is popped and the lane resets to 0. The first word starts at the latched offset.
  - The last pixel handshake (remaining 1→0) pops the FIFO, returns to IDLE, drops vid_busy and pulses vid_done in the next cycle.
  - pix_data is stable while pix_valid=1 and pix_ready=0.
- Collision: a CPU write to a word fetched in the same cycle gives the streamer the old data. Words already in the FIFO are not updated.
- vid_abort (any state): FIFO flushed, in-flight read discarded, pix_valid=0, FSM to IDLE next cycle, no vid_done pulse. vid_abort and vid_start in the same cycle: abort wins.
- The CPU port is fully independent of the streamer; there are no stalls on either side.

Test Plan:
- DATA_W=16: write 0xABCD with be=11 to word 5, then be=01 with 0x1234 → read returns 0xAB34, cpu_rvalid exactly 1 cycle after cpu_re.
- Same-cycle read+write to word 7 (old 0x1111, new 0x2222) → cpu_dout=0x1111; next read → 0x2222.
- Words 0..2 = 0x0102,0x0304,0x0506; stream vid_addr=1, len=4, pix_ready=1 → pixels 02,03,04,05, then one vid_done pulse, vid_busy low.
- Same stream with pix_ready toggling every other cycle → identical pixel sequence; pix_data held during stalls; FIFO occupancy never exceeds FIFO_DEPTH.
- Start at pixel address 2^15-2, len=4 → pixels from word 0x3FFF then words 0x0000 (wrap).
- Abort after 2 of 10 pixels → pix_valid=0 next cycle, no vid_done, FIFO empty. A new start then streams correctly. Start with len=0 → vid_done pulse, no pixels.
